mem_stage: RTL and testbench

- Pipeline MEM stage; the requester side of the MEM port of memCtrl.
- Accepts load/store ops from EX and drives the MEM request to memCtrl (MEM_in/MEMrw/MEMAddr/MEMData/MEMLen).
- Holds the request stable until completion, then sign/zero-extends load data and hands the result to WB.
- Stalls the pipeline for the whole memory transaction; non-memory ops pass through in one cycle.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_load_extend.sv | 23 ++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: funct3 encodings, access lengths, state type.
package mem_stage_pkg;

  typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_e;

  localparam logic READ   = 1'b0;
  localparam logic WRITE  = 1'b1;
  localparam logic ENABLE = 1'b1;
  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Reserved encodings (011, 11x) fall through to a word access.
  function automatic logic [2:0] len_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   len_of = LEN_B;
      2'b01:   len_of = LEN_H;
      default: len_of = LEN_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] len, input logic [1:0] addr_lo);
    misaligned = ((len == LEN_H) && addr_lo[0]) || ((len == LEN_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of zero-padded load data according to funct3.
module mem_stage_load_extend
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] raw_i,
  output logic [DATA_W-1:0] ext_o
);

  always_comb begin
    case (funct3_i)
      F3_B:    ext_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
      F3_BU:   ext_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
      F3_H:    ext_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
      F3_HU:   ext_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
      F3_W:    ext_o = raw_i;
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: requester side of the memCtrl MEM port, stalls for the whole transaction.
// Optional MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing a request.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              exValid_in,
  input  logic              exMemOp_in,
  input  logic              exStore_in,
  input  logic [2:0]        exFunct3_in,
  input  logic [DATA_W-1:0] exAddr_in,
  input  logic [DATA_W-1:0] exData_in,
  input  logic [4:0]        exRd_in,
  input  logic              exWreg_in,
  output logic              MEM_out,
  output logic              MEMrw_out,
  output logic [ADDR_W-1:0] MEMAddr_out,
  output logic [DATA_W-1:0] MEMData_out,
  output logic [2:0]        MEMLen_out,
  input  logic              memDataE_in,
  input  logic [DATA_W-1:0] memData_in,
  output logic              wbE_out,
  output logic [4:0]        wbRd_out,
  output logic [DATA_W-1:0] wbData_out,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_out,
  output logic [ADDR_W-1:0] misAddr_out,
`endif
  output logic              stall_out
);

  state_e              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          len_q, len_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d;
  logic                wreg_q, wreg_d;
  logic                wbe_q, wbe_d;
  logic [4:0]          wbrd_q, wbrd_d;
  logic [DATA_W-1:0]   wbdata_q, wbdata_d;
  logic [DATA_W-1:0]   load_ext;
  logic                req_open;
`ifdef MISALIGN_TRAP_EN
  logic                mis_q, mis_d;
  logic [ADDR_W-1:0]   misaddr_q, misaddr_d;
`endif

  mem_stage_load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .funct3_i (funct3_q),
    .raw_i    (memData_in),
    .ext_o    (load_ext)
  );

  // Request drops in the completion cycle so memCtrl never sees a second request.
  assign req_open = (state_q == StBusy) && (memDataE_in != ENABLE);

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    len_d    = len_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    wreg_d   = wreg_q;
    wbe_d    = 1'b0;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
`ifdef MISALIGN_TRAP_EN
    mis_d     = 1'b0;
    misaddr_d = misaddr_q;
`endif
    case (state_q)
      StIdle: begin
        if (exValid_in) begin
          if (!exMemOp_in) begin
            wbe_d    = exWreg_in;
            wbrd_d   = exRd_in;
            wbdata_d = exAddr_in;
          end else begin
            rw_d     = exStore_in ? WRITE : READ;
            addr_d   = exAddr_in[ADDR_W-1:0];
            data_d   = exData_in;
            len_d    = len_of(exFunct3_in);
            funct3_d = exFunct3_in;
            rd_d     = exRd_in;
            wreg_d   = exWreg_in;
`ifdef MISALIGN_TRAP_EN
            if (misaligned(len_of(exFunct3_in), exAddr_in[1:0])) begin
              mis_d     = 1'b1;
              misaddr_d = exAddr_in[ADDR_W-1:0];
            end else begin
              state_d = StBusy;
            end
`else
            state_d = StBusy;
`endif
          end
        end
      end
      StBusy: begin
        if (memDataE_in) begin
          state_d  = StIdle;
          wbe_d    = wreg_q && (rw_q == READ);
          wbrd_d   = rd_q;
          wbdata_d = load_ext;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      rw_q     <= READ;
      addr_q   <= '0;
      data_q   <= DATA_W'(ZERO32);
      len_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      wreg_q   <= 1'b0;
      wbe_q    <= 1'b0;
      wbrd_q   <= '0;
      wbdata_q <= DATA_W'(ZERO32);
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
      misaddr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      len_q    <= len_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      wreg_q   <= wreg_d;
      wbe_q    <= wbe_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= mis_d;
      misaddr_q <= misaddr_d;
`endif
    end
  end

  assign MEM_out     = req_open;
  assign stall_out   = req_open;
  assign MEMrw_out   = rw_q;
  assign MEMAddr_out = addr_q;
  assign MEMData_out = data_q;
  assign MEMLen_out  = len_q;
  assign wbE_out     = wbe_q;
  assign wbRd_out    = wbrd_q;
  assign wbData_out  = wbdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_out = mis_q;
  assign misAddr_out  = misaddr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized op stream.
module tb_mem_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        exValid_in, exMemOp_in, exStore_in, exWreg_in;
  logic [2:0]  exFunct3_in;
  logic [31:0] exAddr_in, exData_in;
  logic [4:0]  exRd_in;
  logic        MEM_out, MEMrw_out;
  logic [31:0] MEMAddr_out, MEMData_out;
  logic [2:0]  MEMLen_out;
  logic        memDataE_in;
  logic [31:0] memData_in;
  logic        wbE_out;
  logic [4:0]  wbRd_out;
  logic [31:0] wbData_out;
  logic        stall_out;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_out;
  logic [31:0] misAddr_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_stage dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .exValid_in  (exValid_in),
    .exMemOp_in  (exMemOp_in),
    .exStore_in  (exStore_in),
    .exFunct3_in (exFunct3_in),
    .exAddr_in   (exAddr_in),
    .exData_in   (exData_in),
    .exRd_in     (exRd_in),
    .exWreg_in   (exWreg_in),
    .MEM_out     (MEM_out),
    .MEMrw_out   (MEMrw_out),
    .MEMAddr_out (MEMAddr_out),
    .MEMData_out (MEMData_out),
    .MEMLen_out  (MEMLen_out),
    .memDataE_in (memDataE_in),
    .memData_in  (memData_in),
    .wbE_out     (wbE_out),
    .wbRd_out    (wbRd_out),
    .wbData_out  (wbData_out),
`ifdef MISALIGN_TRAP_EN
    .misalign_out(misalign_out),
    .misAddr_out (misAddr_out),
`endif
    .stall_out   (stall_out)
  );

  // Byte count of an access, straight from the funct3 table (reserved codes act as W).
  function automatic int bytes_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // Loaded value as an integer, wrapped to 32 bits.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] raw);
    longint v;
    case (f3)
      3'd0: begin v = raw % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = raw % 256;
      3'd1: begin v = raw % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = raw % 65536;
      default: v = raw;
    endcase
    return 32'(v);
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    exValid_in = 0; exMemOp_in = 0; exStore_in = 0; exWreg_in = 0;
    exFunct3_in = 0; exAddr_in = 0; exData_in = 0; exRd_in = 0;
    memDataE_in = 0; memData_in = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({MEM_out, MEMrw_out, MEMAddr_out, MEMData_out, MEMLen_out, wbE_out, wbRd_out,
         wbData_out, stall_out} !== '0) begin
      errors++;
      $display("FAIL %s outputs: MEM=%b rw=%b addr=%h data=%h len=%0d wbE=%b rd=%0d wbD=%h stall=%b, required all 0",
               tag, MEM_out, MEMrw_out, MEMAddr_out, MEMData_out, MEMLen_out, wbE_out, wbRd_out,
               wbData_out, stall_out);
    end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if ({misalign_out, misAddr_out} !== '0) begin
      errors++;
      $display("FAIL %s misalign: got %b/%h, required 0/0", tag, misalign_out, misAddr_out);
    end
`endif
  endtask

  // Issue one memory op, answer after lat cycles, check request and WB result.
  task automatic mem_op(input string tag, input logic store, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input logic wreg, input logic [31:0] raw, input int lat);
    int n;
    bit mis;
    logic [31:0] padded;
    n = bytes_of(f3);
    mis = (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
    padded = (n == 1) ? raw % 256 : (n == 2) ? raw % 65536 : raw;
    exValid_in = 1; exMemOp_in = 1; exStore_in = store; exFunct3_in = f3;
    exAddr_in = addr; exData_in = data; exRd_in = rd; exWreg_in = wreg;
    #1;
    checks++;
    if (MEM_out !== 1'b0) begin
      errors++; $display("FAIL %s idle_req: got %b, required 0", tag, MEM_out);
    end
    step();
`ifdef MISALIGN_TRAP_EN
    if (mis) begin
      exValid_in = 0;
      checks++;
      if ({misalign_out, misAddr_out, wbE_out, MEM_out, stall_out} !== {1'b1, addr, 3'b000}) begin
        errors++;
        $display("FAIL %s trap: mis=%b maddr=%h wbE=%b MEM=%b stall=%b, required 1 %h 0 0 0",
                 tag, misalign_out, misAddr_out, wbE_out, MEM_out, stall_out, addr);
      end
      step();
      checks++;
      if ({misalign_out, MEM_out} !== 2'b00) begin
        errors++; $display("FAIL %s trap_len: mis=%b MEM=%b, required 0 0", tag, misalign_out, MEM_out);
      end
      exMemOp_in = 0;
      return;
    end
`endif
    checks++;
    if (wbE_out !== 1'b0) begin
      errors++; $display("FAIL %s accept_wbE: got %b, required 0", tag, wbE_out);
    end
    for (int i = 0; i < lat; i++) begin
      checks++;
      if ({MEM_out, stall_out, MEMrw_out, MEMAddr_out, MEMData_out, MEMLen_out} !==
          {1'b1, 1'b1, store, addr, data, 3'(n)}) begin
        errors++;
        $display("FAIL %s busy%0d: MEM=%b stall=%b rw=%b addr=%h data=%h len=%0d, required 1 1 %b %h %h %0d",
                 tag, i, MEM_out, stall_out, MEMrw_out, MEMAddr_out, MEMData_out, MEMLen_out,
                 store, addr, data, n);
      end
      step();
    end
    memDataE_in = 1; memData_in = padded;
    #1;
    checks++;
    if ({MEM_out, stall_out} !== 2'b00) begin
      errors++; $display("FAIL %s done_req: MEM=%b stall=%b, required 0 0", tag, MEM_out, stall_out);
    end
    step();
    memDataE_in = 0; exValid_in = 0; exMemOp_in = 0;
    checks++;
    if (wbE_out !== (wreg && !store)) begin
      errors++; $display("FAIL %s wbE: got %b, required %b", tag, wbE_out, wreg && !store);
    end
    if (!store) begin
      checks++;
      if ({wbRd_out, wbData_out} !== {rd, ref_load(f3, padded)}) begin
        errors++;
        $display("FAIL %s wb: rd=%0d data=%h, required rd=%0d data=%h", tag, wbRd_out, wbData_out,
                 rd, ref_load(f3, padded));
      end
    end
  endtask

  task automatic non_mem(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                         input logic wreg);
    exValid_in = 1; exMemOp_in = 0; exStore_in = $urandom_range(0, 1); exFunct3_in = 3'd2;
    exAddr_in = addr; exRd_in = rd; exWreg_in = wreg; exData_in = $urandom;
    step();
    exValid_in = 0;
    checks++;
    if ({wbE_out, wbRd_out, wbData_out, MEM_out, stall_out} !== {wreg, rd, addr, 2'b00}) begin
      errors++;
      $display("FAIL %s passthru: wbE=%b rd=%0d data=%h MEM=%b stall=%b, required %b %0d %h 0 0",
               tag, wbE_out, wbRd_out, wbData_out, MEM_out, stall_out, wreg, rd, addr);
    end
  endtask

  task automatic test_reset();
    rst_in = 0;
    idle_inputs();
    step();
    step();
    check_all_zero("reset");
    rst_in = 1;
    step();
  endtask

  task automatic test_lb_sign();
    mem_op("lb_sign", 1'b0, 3'd0, 32'h1003, 32'h0, 5'd3, 1'b1, 32'h0000_0080, 3);
  endtask

  task automatic test_lhu();
    mem_op("lhu", 1'b0, 3'd5, 32'h2000, 32'h0, 5'd9, 1'b1, 32'h0000_F00D, 2);
  endtask

  task automatic test_sw();
    mem_op("sw", 1'b1, 3'd2, 32'h3000, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h0, 4);
  endtask

  task automatic test_back_to_back();
    mem_op("b2b_lw", 1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd12, 1'b1, 32'h1234_5678, 2);
    non_mem("b2b_alu", 32'h55, 5'd7, 1'b1);
    mem_op("b2b_lh", 1'b0, 3'd1, 32'h0000_0202, 32'h0, 5'd13, 1'b1, 32'h0000_8001, 1);
  endtask

  task automatic test_reset_mid_busy();
    exValid_in = 1; exMemOp_in = 1; exStore_in = 0; exFunct3_in = 3'd2;
    exAddr_in = 32'h0000_0400; exRd_in = 5'd5; exWreg_in = 1; exData_in = 32'hA5A5_A5A5;
    step();
    step();
    rst_in = 0; exValid_in = 0; exMemOp_in = 0;
    step();
    rst_in = 1;
    check_all_zero("rst_busy");
    memDataE_in = 1; memData_in = 32'hCAFE_F00D;
    step();
    memDataE_in = 0;
    checks++;
    if ({wbE_out, MEM_out, stall_out} !== 3'b000) begin
      errors++;
      $display("FAIL rst_stray: wbE=%b MEM=%b stall=%b, required 0 0 0", wbE_out, MEM_out, stall_out);
    end
  endtask

  task automatic test_misalign();
    mem_op("lw_mis", 1'b0, 3'd2, 32'h4002, 32'h0, 5'd6, 1'b1, 32'h0BAD_CAFE, 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        non_mem("rnd_alu", $urandom, 5'($urandom), 1'($urandom));
      end else begin
        mem_op("rnd_mem", 1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
               5'($urandom), 1'($urandom), $urandom, $urandom_range(1, 4));
      end
      if ($urandom_range(0, 3) == 0) begin
        memDataE_in = 1; memData_in = $urandom;
        step();
        memDataE_in = 0;
        checks++;
        if ({wbE_out, MEM_out} !== 2'b00) begin
          errors++; $display("FAIL rnd_stray: wbE=%b MEM=%b, required 0 0", wbE_out, MEM_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lhu();
    test_sw();
    test_back_to_back();
    test_reset_mid_busy();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
